// File: rtl/vend_controller.sv
// Guffin vending sequencer: accumulates coin credit in quarters, dispenses at PRICE,
// and pays change or refunds one coin per hopper handshake.
module vend_controller #(
    parameter int unsigned CREDIT_W = 4,
    parameter int unsigned PRICE    = 6
) (
    input  logic                CLK,
    input  logic                RES,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    input  logic                cancel,
    input  logic                hop_ready,
    output logic                guffin,
    output logic                half_out,
    output logic                qtr_out,
    output logic                coin_reject,
    output logic [2:0]          state_code,
    output logic [CREDIT_W-1:0] credit
);

    localparam int unsigned SUM_W      = CREDIT_W + 1;
    localparam int unsigned CREDIT_MAX = (1 << CREDIT_W) - 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        VEND    = 3'd2,
        CHANGE  = 3'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                guffin_q, guffin_d;
    logic                half_q, half_d;
    logic                qtr_q, qtr_d;
    logic                reject_q, reject_d;

    logic [2:0]          coin_val;
    logic                coin_nz;
    logic                can_take;
    logic                accept;
    logic [SUM_W-1:0]    credit_ext;
    logic [SUM_W-1:0]    sum;
    logic [SUM_W-1:0]    chg_amt;
    logic                pay_half;
    logic [CREDIT_W-1:0] vend_rem;
    logic [CREDIT_W-1:0] chg_rem;

    // Coin decode: quarter units, code 00 carries no value
    always_comb begin
        coin_val = 3'd0;
        case (coin_code)
            2'b01:   coin_val = 3'd1;
            2'b10:   coin_val = 3'd2;
            2'b11:   coin_val = 3'd4;
            default: coin_val = 3'd0;
        endcase
    end

    assign coin_nz    = coin_valid && (coin_code != 2'b00);
    assign credit_ext = {1'b0, credit_q};
    assign sum        = credit_ext + SUM_W'(coin_val);
    assign can_take   = (state_q == IDLE) || (state_q == COLLECT);
    assign accept     = coin_nz && can_take && !cancel && (sum <= SUM_W'(CREDIT_MAX));

    // Change pays the largest coin that fits; remainder after vend is never negative
    assign pay_half = (credit_ext >= SUM_W'(2));
    assign chg_amt  = pay_half ? SUM_W'(2) : SUM_W'(1);
    assign chg_rem  = CREDIT_W'(credit_ext - chg_amt);
    assign vend_rem = credit_q - CREDIT_W'(PRICE);

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        guffin_d = 1'b0;
        half_d   = 1'b0;
        qtr_d    = 1'b0;
        reject_d = coin_nz && !accept;

        case (state_q)
            IDLE, COLLECT: begin
                if (accept) begin
                    credit_d = sum[CREDIT_W-1:0];
                    if (sum >= SUM_W'(PRICE)) begin
                        state_d  = VEND;
                        guffin_d = 1'b1;
                    end else begin
                        state_d = COLLECT;
                    end
                end else if ((state_q == COLLECT) && cancel) begin
                    state_d = CHANGE;
                end
            end
            VEND: begin
                credit_d = vend_rem;
                state_d  = (vend_rem != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                if (hop_ready) begin
                    credit_d = chg_rem;
                    half_d   = pay_half;
                    qtr_d    = !pay_half;
                    if (chg_rem == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    // State and registered outputs; reset drops any pending change
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state_q  <= IDLE;
            credit_q <= '0;
            guffin_q <= 1'b0;
            half_q   <= 1'b0;
            qtr_q    <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            guffin_q <= guffin_d;
            half_q   <= half_d;
            qtr_q    <= qtr_d;
            reject_q <= reject_d;
        end
    end

    assign guffin      = guffin_q;
    assign half_out    = half_q;
    assign qtr_out     = qtr_q;
    assign coin_reject = reject_q;
    assign state_code  = state_q;
    assign credit      = credit_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: table of single-cycle vectors on a PRICE=6 instance,
// plus hand sequences for mid-cycle reset and the overflow corner on a PRICE=14 instance.
module tb_vend_controller;

    logic       CLK = 1'b0;
    logic       RES;
    logic       coin_valid;
    logic [1:0] coin_code;
    logic       cancel;
    logic       hop_ready;

    logic       g_a, h_a, q_a, r_a;
    logic [2:0] st_a;
    logic [3:0] cr_a;
    logic       g_b, h_b, q_b, r_b;
    logic [2:0] st_b;
    logic [3:0] cr_b;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    vend_controller #(.CREDIT_W(4), .PRICE(6)) dut_a (
        .CLK(CLK), .RES(RES), .coin_valid(coin_valid), .coin_code(coin_code),
        .cancel(cancel), .hop_ready(hop_ready), .guffin(g_a), .half_out(h_a),
        .qtr_out(q_a), .coin_reject(r_a), .state_code(st_a), .credit(cr_a)
    );

    vend_controller #(.CREDIT_W(4), .PRICE(14)) dut_b (
        .CLK(CLK), .RES(RES), .coin_valid(coin_valid), .coin_code(coin_code),
        .cancel(cancel), .hop_ready(hop_ready), .guffin(g_b), .half_out(h_b),
        .qtr_out(q_b), .coin_reject(r_b), .state_code(st_b), .credit(cr_b)
    );

    typedef struct {
        string      name;
        logic       cv;
        logic [1:0] code;
        logic       can;
        logic       hop;
        logic [10:0] exp;   // {guffin, half, qtr, reject, state[2:0], credit[3:0]}
    } vec_t;

    vec_t vecs[$];

    localparam logic [1:0] NONE = 2'b00, QTR = 2'b01, HALF = 2'b10, DOL = 2'b11;

    function automatic vec_t mk(string n, logic cv, logic [1:0] code, logic can, logic hop,
                                logic g, logic h, logic q, logic r,
                                logic [2:0] st, logic [3:0] cr);
        vec_t v;
        v.name = n; v.cv = cv; v.code = code; v.can = can; v.hop = hop;
        v.exp  = {g, h, q, r, st, cr};
        return v;
    endfunction

    function automatic logic [10:0] pack_a();
        return {g_a, h_a, q_a, r_a, st_a, cr_a};
    endfunction

    function automatic logic [10:0] pack_b();
        return {g_b, h_b, q_b, r_b, st_b, cr_b};
    endfunction

    task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got g%b h%b q%b r%b st=%0d cr=%0d, want g%b h%b q%b r%b st=%0d cr=%0d",
                     name, act[10], act[9], act[8], act[7], act[6:4], act[3:0],
                     exp[10], exp[9], exp[8], exp[7], exp[6:4], exp[3:0]);
        end
    endtask

    task automatic drive(input logic cv, input logic [1:0] code, input logic can, input logic hop);
        coin_valid = cv; coin_code = code; cancel = can; hop_ready = hop;
    endtask

    task automatic step(input logic cv, input logic [1:0] code, input logic can, input logic hop);
        drive(cv, code, can, hop);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Vectors for PRICE=6: outputs expected one edge after the inputs are applied
        vecs.push_back(mk("p6_dollar",        1, DOL,  0, 0, 0,0,0,0, 3'd1, 4'd4));
        vecs.push_back(mk("p6_half_vend",     1, HALF, 0, 0, 1,0,0,0, 3'd2, 4'd6));
        vecs.push_back(mk("p6_exact_idle",    0, NONE, 0, 0, 0,0,0,0, 3'd0, 4'd0));
        vecs.push_back(mk("p6_quiet",         0, NONE, 0, 0, 0,0,0,0, 3'd0, 4'd0));
        vecs.push_back(mk("dd_first",         1, DOL,  0, 1, 0,0,0,0, 3'd1, 4'd4));
        vecs.push_back(mk("dd_vend",          1, DOL,  0, 1, 1,0,0,0, 3'd2, 4'd8));
        vecs.push_back(mk("dd_exit_change",   0, NONE, 0, 1, 0,0,0,0, 3'd3, 4'd2));
        vecs.push_back(mk("dd_half_out",      0, NONE, 0, 1, 0,1,0,0, 3'd0, 4'd0));
        vecs.push_back(mk("dd_quiet",         0, NONE, 0, 1, 0,0,0,0, 3'd0, 4'd0));
        vecs.push_back(mk("cx_quarter",       1, QTR,  0, 0, 0,0,0,0, 3'd1, 4'd1));
        vecs.push_back(mk("cx_cancel",        0, NONE, 1, 0, 0,0,0,0, 3'd3, 4'd1));
        vecs.push_back(mk("cx_hold1",         0, NONE, 0, 0, 0,0,0,0, 3'd3, 4'd1));
        vecs.push_back(mk("cx_hold2",         0, NONE, 0, 0, 0,0,0,0, 3'd3, 4'd1));
        vecs.push_back(mk("cx_hold3",         0, NONE, 0, 0, 0,0,0,0, 3'd3, 4'd1));
        vecs.push_back(mk("cx_qtr_out",       0, NONE, 0, 1, 0,0,1,0, 3'd0, 4'd0));
        vecs.push_back(mk("cx_quiet",         0, NONE, 0, 0, 0,0,0,0, 3'd0, 4'd0));
        vecs.push_back(mk("rj_half",          1, HALF, 0, 0, 0,0,0,0, 3'd1, 4'd2));
        vecs.push_back(mk("rj_coin_cancel",   1, QTR,  1, 0, 0,0,0,1, 3'd3, 4'd2));
        vecs.push_back(mk("rj_in_change",     1, DOL,  0, 0, 0,0,0,1, 3'd3, 4'd2));
        vecs.push_back(mk("rj_refund",        0, NONE, 0, 1, 0,1,0,0, 3'd0, 4'd0));
        vecs.push_back(mk("rj_quiet",         0, NONE, 0, 0, 0,0,0,0, 3'd0, 4'd0));
        vecs.push_back(mk("code00_noop",      1, NONE, 0, 0, 0,0,0,0, 3'd0, 4'd0));
        vecs.push_back(mk("cancel_idle",      0, NONE, 1, 0, 0,0,0,0, 3'd0, 4'd0));
        vecs.push_back(mk("vr_dollar",        1, DOL,  0, 0, 0,0,0,0, 3'd1, 4'd4));
        vecs.push_back(mk("vr_vend",          1, DOL,  0, 0, 1,0,0,0, 3'd2, 4'd8));
        vecs.push_back(mk("vr_coin_in_vend",  1, QTR,  0, 0, 0,0,0,1, 3'd3, 4'd2));
        vecs.push_back(mk("vr_half",          0, NONE, 0, 1, 0,1,0,0, 3'd0, 4'd0));
        vecs.push_back(mk("c3_quarter",       1, QTR,  0, 0, 0,0,0,0, 3'd1, 4'd1));
        vecs.push_back(mk("c3_dollar",        1, DOL,  0, 0, 0,0,0,0, 3'd1, 4'd5));
        vecs.push_back(mk("c3_vend",          1, DOL,  0, 1, 1,0,0,0, 3'd2, 4'd9));
        vecs.push_back(mk("c3_exit",          0, NONE, 0, 1, 0,0,0,0, 3'd3, 4'd3));
        vecs.push_back(mk("c3_half",          0, NONE, 0, 1, 0,1,0,0, 3'd3, 4'd1));
        vecs.push_back(mk("c3_qtr",           0, NONE, 0, 1, 0,0,1,0, 3'd0, 4'd0));
        vecs.push_back(mk("c3_quiet",         0, NONE, 0, 1, 0,0,0,0, 3'd0, 4'd0));

        RES = 1'b0;
        drive(0, NONE, 0, 0);
        #12;
        chk("reset_a", pack_a(), 11'd0);
        chk("reset_b", pack_b(), 11'd0);
        #11 RES = 1'b1;
        @(posedge CLK);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].cv, vecs[i].code, vecs[i].can, vecs[i].hop);
            chk(vecs[i].name, pack_a(), vecs[i].exp);
        end

        // Park A in CHANGE with credit 2, then reset mid-cycle
        step(1, DOL, 0, 0);
        step(1, DOL, 0, 0);
        step(0, NONE, 0, 0);
        chk("pre_reset_change", pack_a(), {4'b0000, 3'd3, 4'd2});
        #3 RES = 1'b0;
        #1;
        chk("async_reset_a", pack_a(), 11'd0);
        chk("async_reset_b", pack_b(), 11'd0);
        drive(0, NONE, 0, 1);
        @(posedge CLK);
        #1;
        chk("reset_hold_a", pack_a(), 11'd0);
        #3 RES = 1'b1;
        step(1, QTR, 0, 0);
        chk("first_coin_a", pack_a(), {4'b0000, 3'd1, 4'd1});
        chk("first_coin_b", pack_b(), {4'b0000, 3'd1, 4'd1});

        // PRICE=14: climb to 13, overflowing dollar rejected, quarter reaches price
        step(1, DOL, 0, 0);
        chk("p14_5",  pack_b(), {4'b0000, 3'd1, 4'd5});
        step(1, DOL, 0, 0);
        chk("p14_9",  pack_b(), {4'b0000, 3'd1, 4'd9});
        step(1, DOL, 0, 0);
        chk("p14_13", pack_b(), {4'b0000, 3'd1, 4'd13});
        step(1, DOL, 0, 0);
        chk("p14_overflow_reject", pack_b(), {4'b0001, 3'd1, 4'd13});
        step(1, QTR, 0, 0);
        chk("p14_vend", pack_b(), {4'b1000, 3'd2, 4'd14});
        step(0, NONE, 0, 0);
        chk("p14_idle", pack_b(), {4'b0000, 3'd0, 4'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
